// File: rtl/pmod_spi_master_pkg.sv
// Shared types and defaults for the PMOD SPI master: FSM state encoding and
// default geometry.
package pmod_spi_master_pkg;

  localparam int CLK_DIV_DEFAULT = 4;
  localparam int DATA_W_DEFAULT  = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WAIT_NEXT = 3'd3,
    ST_HOLD      = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

endpackage

// File: rtl/pmod_spi_master_if.sv
// Byte handshake between the MicroBlaze-side logic (master modport) and the
// SPI engine (slave modport).
interface pmod_spi_master_if
  import pmod_spi_master_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;

  modport master (
    output tx_data, tx_last, tx_valid,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_last, tx_valid,
    output tx_ready, rx_data, rx_valid
  );

endinterface

// File: rtl/pmod_spi_master_clk_tick.sv
// SCK half-period timer: o_tick is high on the last clk of each half-period;
// i_clr parks the count at zero.
module spi_clk_tick
  import pmod_spi_master_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_at_end;

  assign w_at_end = (r_cnt == CW'(CLK_DIV - 1));
  assign o_tick   = w_at_end & ~i_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_at_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pmod_spi_master.sv
// Byte-wide SPI master, MSB first, all four CPOL/CPHA modes, feeding the PMOD
// port mux. Shift registers and the FSM live here; timing comes from spi_clk_tick.
module pmod_spi_master
  import pmod_spi_master_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DATA_W  = DATA_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  pmod_spi_master_if.slave   bus,
  input  logic               i_cpol,
  input  logic               i_cpha,
  output logic               o_busy,
  output logic               o_spi_ss,
  output logic               o_spi_mosi,
  input  logic               i_spi_miso,
  output logic               o_spi_sck
);

  localparam int BW  = $clog2(DATA_W + 1);
  localparam int MSB = DATA_W - 1;

  state_t            r_state;
  logic              r_cpha;
  logic              r_last;
  logic              r_lead;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_tx_ready;
  logic              r_busy;
  logic              r_ss;
  logic              r_sck;
  logic              r_mosi;

  logic              w_tick;
  logic              w_clr;
  logic              w_accept;
  logic              w_last_bit;
  logic [DATA_W-1:0] w_sample;

  // The timer only runs in states that wait out a half-period.
  assign w_clr      = (r_state == ST_IDLE) || (r_state == ST_WAIT_NEXT);
  assign w_accept   = bus.tx_valid & r_tx_ready;
  assign w_last_bit = (r_bit == BW'(DATA_W - 1));
  assign w_sample   = {r_rx[DATA_W-2:0], i_spi_miso};

  spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cpha     <= 1'b0;
      r_last     <= 1'b0;
      r_lead     <= 1'b1;
      r_bit      <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_ss       <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx_ready <= 1'b1;
          r_sck      <= i_cpol;
          if (w_accept) begin
            r_cpha     <= i_cpha;
            r_tx       <= bus.tx_data;
            r_last     <= bus.tx_last;
            r_bit      <= '0;
            r_lead     <= 1'b1;
            if (!i_cpha) r_mosi <= bus.tx_data[MSB];
            r_tx_ready <= 1'b0;
            r_ss       <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (w_tick) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_tick) begin
            r_sck  <= ~r_sck;
            r_lead <= ~r_lead;
            if (r_lead) begin
              if (!r_cpha) begin
                r_rx <= w_sample;
              end else begin
                r_mosi <= r_tx[MSB];
                r_tx   <= r_tx << 1;
              end
            end else begin
              if (r_cpha) begin
                r_rx <= w_sample;
              end else if (!w_last_bit) begin
                r_mosi <= r_tx[MSB-1];
                r_tx   <= r_tx << 1;
              end
              if (w_last_bit) begin
                // cpha=1 takes its final bit on this very edge.
                r_rx_data  <= r_cpha ? w_sample : r_rx;
                r_rx_valid <= 1'b1;
                if (r_last) begin
                  r_state <= ST_HOLD;
                end else begin
                  r_tx_ready <= 1'b1;
                  r_state    <= ST_WAIT_NEXT;
                end
              end else begin
                r_bit <= r_bit + 1'b1;
              end
            end
          end
        end
        ST_WAIT_NEXT: begin
          if (w_accept) begin
            r_tx       <= bus.tx_data;
            r_last     <= bus.tx_last;
            r_bit      <= '0;
            r_lead     <= 1'b1;
            if (!r_cpha) r_mosi <= bus.tx_data[MSB];
            r_tx_ready <= 1'b0;
            r_state    <= ST_SETUP;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_ss    <= 1'b1;
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_ready = r_tx_ready;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign o_busy       = r_busy;
  assign o_spi_ss     = r_ss;
  assign o_spi_sck    = r_sck;
  assign o_spi_mosi   = r_mosi;

endmodule

// File: tb/tb_pmod_spi_master.sv
// Directed bench for pmod_spi_master: loopback and a mode-aware slave model,
// with a negedge monitor that counts edges, words and handshakes.
module tb_pmod_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_cpol = 1'b0;
  logic i_cpha = 1'b0;
  logic o_busy, o_spi_ss, o_spi_mosi, o_spi_sck;
  logic w_miso;
  logic loop_en = 1'b1;

  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  logic [7:0] s_reply = 8'h00;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_rx = 8'h00;
  logic       s_miso = 1'b0;

  int chk_cnt = 0;
  int err_cnt = 0;

  int cyc = 0;
  int rise_cnt = 0, ss_low_cnt = 0, ss_rise_cnt = 0, mosi_bad = 0;
  int acc_cnt = 0, rxv_cnt = 0, rxv_rdy_cnt = 0;
  int cyc_ss_rise = 0, cyc_busy_fall = 0, cyc_acc = 0;
  logic [7:0] rx_hist [0:63];
  int         rx_cyc  [0:63];
  logic [7:0] last_rx = 8'h00;
  logic       sck_at_rxv = 1'b0;
  logic p_sck = 1'b0, p_ss = 1'b1, p_mosi = 1'b0, p_busy = 1'b0;

  pmod_spi_master_if #(.DATA_W(8)) bus ();

  assign w_miso = loop_en ? o_spi_mosi : s_miso;

  pmod_spi_master #(.CLK_DIV(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .i_cpol     (i_cpol),
    .i_cpha     (i_cpha),
    .o_busy     (o_busy),
    .o_spi_ss   (o_spi_ss),
    .o_spi_mosi (o_spi_mosi),
    .i_spi_miso (w_miso),
    .o_spi_sck  (o_spi_sck)
  );

  always #5 clk = ~clk;

  // Monitor and slave model, both sampled away from the active edge.
  always @(negedge clk) begin
    logic lead;
    cyc = cyc + 1;
    if (o_spi_sck && !p_sck) rise_cnt = rise_cnt + 1;
    if (!o_spi_ss) ss_low_cnt = ss_low_cnt + 1;
    if (o_spi_ss && !p_ss) begin
      ss_rise_cnt = ss_rise_cnt + 1;
      cyc_ss_rise = cyc;
    end
    if (!o_busy && p_busy) cyc_busy_fall = cyc;
    if ((o_spi_mosi != p_mosi) && !(p_sck && !o_spi_sck)) mosi_bad = mosi_bad + 1;
    if (bus.tx_valid && bus.tx_ready) begin
      acc_cnt = acc_cnt + 1;
      cyc_acc = cyc;
    end
    if (bus.rx_valid) begin
      rx_hist[rxv_cnt % 64] = bus.rx_data;
      rx_cyc[rxv_cnt % 64]  = cyc;
      rxv_cnt = rxv_cnt + 1;
      last_rx = bus.rx_data;
      sck_at_rxv = o_spi_sck;
      if (bus.tx_ready) rxv_rdy_cnt = rxv_rdy_cnt + 1;
      $display("rx word 0x%02h at cycle %0d", bus.rx_data, cyc);
    end
    if (p_ss && !o_spi_ss) begin
      s_sh = s_reply;
      s_rx = 8'h00;
      if (!s_cpha) s_miso = s_sh[7];
    end else if (!o_spi_ss && (o_spi_sck != p_sck)) begin
      lead = (o_spi_sck != s_cpol);
      if (lead ^ s_cpha) begin
        s_rx = {s_rx[6:0], o_spi_mosi};
      end else if (s_cpha) begin
        s_miso = s_sh[7];
        s_sh   = s_sh << 1;
      end else begin
        s_sh   = s_sh << 1;
        s_miso = s_sh[7];
      end
    end
    p_sck  = o_spi_sck;
    p_ss   = o_spi_ss;
    p_mosi = o_spi_mosi;
    p_busy = o_busy;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt = chk_cnt + 1;
    if (got !== exp) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_word(input logic [7:0] data, input logic last);
    bit done = 1'b0;
    @(posedge clk) #1;
    bus.tx_data  = data;
    bus.tx_last  = last;
    bus.tx_valid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (bus.tx_ready) done = 1'b1;
    end
    if (!done) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk) #1;
    bus.tx_valid = 1'b0;
    $display("tx word 0x%02h last=%0d accepted=%0d", data, last, done);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (!o_busy && bus.tx_ready) done = 1'b1;
    end
    if (!done) check_val("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rxv(input int target);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (rxv_cnt >= target) done = 1'b1;
    end
    if (!done) check_val("rxv_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rise(input int target);
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (rise_cnt >= target) done = 1'b1;
    end
    if (!done) check_val("rise_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int r0, l0, v0, a0, b0, q0, s0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    bus.tx_valid = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_ss",       32'(o_spi_ss),     32'd1);
    check_val("rst_sck",      32'(o_spi_sck),    32'd0);
    check_val("rst_mosi",     32'(o_spi_mosi),   32'd0);
    check_val("rst_ready",    32'(bus.tx_ready), 32'd0);
    check_val("rst_rx_data",  32'(bus.rx_data),  32'd0);
    check_val("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_val("rst_busy",     32'(o_busy),       32'd0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: mode 0 loopback, single word
    loop_en = 1'b1; i_cpol = 1'b0; i_cpha = 1'b0;
    r0 = rise_cnt; l0 = ss_low_cnt; v0 = rxv_cnt;
    send_word(8'hA5, 1'b1);
    wait_idle();
    check_val("t1_rx_data",   32'(last_rx),       'hA5);
    check_val("t1_rxv_count", 32'(rxv_cnt - v0),  32'd1);
    check_val("t1_sck_rises", 32'(rise_cnt - r0), 32'd8);
    check_val("t1_ss_low",    32'(ss_low_cnt - l0), 32'd72);
    check_val("t1_gap",       32'(cyc_busy_fall - cyc_ss_rise), 32'd4);

    // 2: mode 3 against slave model
    loop_en = 1'b0; i_cpol = 1'b1; i_cpha = 1'b1;
    s_cpol = 1'b1; s_cpha = 1'b1; s_reply = 8'h3C;
    repeat (3) @(negedge clk);
    check_val("t2_sck_idle", 32'(o_spi_sck), 32'd1);
    b0 = mosi_bad;
    send_word(8'h81, 1'b1);
    wait_idle();
    check_val("t2_rx_data",   32'(last_rx),       'h3C);
    check_val("t2_slave_rx",  32'(s_rx),          'h81);
    check_val("t2_mosi_edge", 32'(mosi_bad - b0), 32'd0);
    check_val("t2_sck_end",   32'(o_spi_sck),     32'd1);

    // 3: three-word burst with gaps between words
    loop_en = 1'b1; i_cpol = 1'b0; i_cpha = 1'b0;
    repeat (3) @(negedge clk);
    s0 = ss_rise_cnt; v0 = rxv_cnt; q0 = rxv_rdy_cnt;
    send_word(8'h11, 1'b0); wait_rxv(v0 + 1); repeat (10) @(negedge clk);
    send_word(8'h22, 1'b0); wait_rxv(v0 + 2); repeat (10) @(negedge clk);
    send_word(8'h33, 1'b1);
    wait_idle();
    check_val("t3_rxv_count", 32'(rxv_cnt - v0),     32'd3);
    check_val("t3_word0",     32'(rx_hist[v0 % 64]),       'h11);
    check_val("t3_word1",     32'(rx_hist[(v0 + 1) % 64]), 'h22);
    check_val("t3_word2",     32'(rx_hist[(v0 + 2) % 64]), 'h33);
    check_val("t3_ss_rises",  32'(ss_rise_cnt - s0), 32'd1);
    check_val("t3_ss_hold",   32'(cyc_ss_rise - rx_cyc[(v0 + 2) % 64]), 32'd4);
    check_val("t3_rxv_ready", 32'(rxv_rdy_cnt - q0), 32'd2);

    // 4: second word offered during SHIFT
    a0 = acc_cnt; v0 = rxv_cnt;
    send_word(8'h44, 1'b0);
    send_word(8'h55, 1'b1);
    wait_idle();
    check_val("t4_accepts",   32'(acc_cnt - a0), 32'd2);
    check_val("t4_rxv_count", 32'(rxv_cnt - v0), 32'd2);
    check_val("t4_word0",     32'(rx_hist[v0 % 64]),       'h44);
    check_val("t4_word1",     32'(rx_hist[(v0 + 1) % 64]), 'h55);
    check_val("t4_accept_at", 32'(cyc_acc), 32'(rx_cyc[v0 % 64]));

    // 5: async reset mid-word
    r0 = rise_cnt;
    send_word(8'h5A, 1'b1);
    wait_rise(r0 + 4);
    #2 rst_n = 1'b0;
    #1;
    v0 = rxv_cnt;
    check_val("t5_ss",       32'(o_spi_ss),     32'd1);
    check_val("t5_sck",      32'(o_spi_sck),    32'd0);
    check_val("t5_rx_valid", 32'(bus.rx_valid), 32'd0);
    check_val("t5_busy",     32'(o_busy),       32'd0);
    check_val("t5_ready",    32'(bus.tx_ready), 32'd0);
    check_val("t5_rx_data",  32'(bus.rx_data),  32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_val("t5_no_partial", 32'(rxv_cnt - v0), 32'd0);
    send_word(8'hF0, 1'b1);
    wait_idle();
    check_val("t5_rx_after", 32'(last_rx),      'hF0);
    check_val("t5_rxv_once", 32'(rxv_cnt - v0), 32'd1);

    // 6: cpol changed mid-frame takes effect only on the next frame
    send_word(8'hC3, 1'b1);
    repeat (8) @(negedge clk);
    i_cpol = 1'b1;
    wait_idle();
    check_val("t6_rx_old",    32'(last_rx),    'hC3);
    check_val("t6_sck_old",   32'(sck_at_rxv), 32'd0);
    repeat (2) @(negedge clk);
    check_val("t6_sck_idle",  32'(o_spi_sck),  32'd1);
    loop_en = 1'b0; s_cpol = 1'b1; s_cpha = 1'b0; s_reply = 8'h96;
    send_word(8'h69, 1'b1);
    wait_idle();
    check_val("t6_rx_new",    32'(last_rx),    'h96);
    check_val("t6_slave_rx",  32'(s_rx),       'h69);
    check_val("t6_sck_new",   32'(sck_at_rxv), 32'd1);

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
